// File: rtl/upsize_sync_fifo.sv
// Single-clock FIFO that packs RATIO narrow write words into one wide read word.
// Supports partial-word flush with a per-word valid-lane count and sticky error flags.
module upsize_sync_fifo #(
    parameter int    WR_DATA_WIDTH    = 32,
    parameter int    RATIO            = 8,
    parameter int    RD_DEPTH_WIDTH   = 10,
    parameter int    ALMOST_FULL_NUM  = 1020,
    parameter int    ALMOST_EMPTY_NUM = 4,
    parameter string PACK_ORDER       = "LSB_FIRST",
    localparam int   LW               = $clog2(RATIO + 1),
    localparam int   RD_DATA_WIDTH    = WR_DATA_WIDTH * RATIO,
    localparam int   WWL_W            = RD_DEPTH_WIDTH + $clog2(RATIO) + 1
) (
    input  logic                      clk,
    input  logic                      tb_rst,
    input  logic                      wr_en,
    input  logic [WR_DATA_WIDTH-1:0]  wr_data,
    input  logic                      wr_flush,
    output logic                      wr_full,
    output logic                      almost_full,
    output logic [WWL_W-1:0]          wr_water_level,
    input  logic                      rd_en,
    output logic [RD_DATA_WIDTH-1:0]  rd_data,
    output logic [LW-1:0]             rd_lanes,
    output logic                      rd_empty,
    output logic                      almost_empty,
    output logic [RD_DEPTH_WIDTH:0]   rd_water_level,
    output logic                      overflow,
    output logic                      underflow,
    input  logic                      err_clr
);

    localparam int              DEPTH      = 2 ** RD_DEPTH_WIDTH;
    localparam int              CW         = RD_DEPTH_WIDTH + 1;
    localparam int              MW         = RD_DATA_WIDTH + LW;
    localparam bit              MSB_FIRST  = (PACK_ORDER == "MSB_FIRST");
    localparam logic [CW-1:0]   COUNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0]   AF_LEVEL   = CW'(ALMOST_FULL_NUM);
    localparam logic [CW-1:0]   AE_LEVEL   = CW'(ALMOST_EMPTY_NUM);
    localparam logic [LW-1:0]   LAST_LANE  = LW'(RATIO - 1);
    localparam logic [LW-1:0]   ALL_LANES  = LW'(RATIO);

    logic [MW-1:0]               mem_q [DEPTH];
    logic [RD_DEPTH_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [RD_DEPTH_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]               count_q, count_d;
    logic [LW-1:0]               lane_cnt_q, lane_cnt_d;
    logic [RD_DATA_WIDTH-1:0]    packer_q, packer_d;
    logic [RD_DATA_WIDTH-1:0]    rd_data_q, rd_data_d;
    logic [LW-1:0]               rd_lanes_q, rd_lanes_d;
    logic                        overflow_q, overflow_d;
    logic                        underflow_q, underflow_d;

    logic                        count_full;
    logic                        wr_accept;
    logic                        push_req;
    logic                        push;
    logic                        pop;
    logic [LW-1:0]               lane_next;
    logic [RD_DATA_WIDTH-1:0]    packer_next;
    int                          lane_idx;

    // Status flags look only at registered state, so same-cycle traffic never affects them.
    assign count_full     = (count_q == COUNT_FULL);
    assign wr_full        = count_full && (lane_cnt_q == LAST_LANE);
    assign rd_empty       = (count_q == '0);
    assign almost_full    = (count_q >= AF_LEVEL);
    assign almost_empty   = (count_q <= AE_LEVEL);
    assign rd_water_level = count_q;
    assign wr_water_level = WWL_W'(count_q) * WWL_W'(RATIO) + WWL_W'(lane_cnt_q);
    assign rd_data        = rd_data_q;
    assign rd_lanes       = rd_lanes_q;
    assign overflow       = overflow_q;
    assign underflow      = underflow_q;

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        wr_accept   = wr_en && !wr_full;
        lane_idx    = MSB_FIRST ? (RATIO - 1 - int'(lane_cnt_q)) : int'(lane_cnt_q);
        packer_next = packer_q;
        if (wr_accept) begin
            packer_next[lane_idx*WR_DATA_WIDTH +: WR_DATA_WIDTH] = wr_data;
        end
        lane_next = lane_cnt_q + LW'(wr_accept);
        push_req  = (lane_next != '0) && ((lane_next == ALL_LANES) || wr_flush);
        push      = push_req && !count_full;
        pop       = rd_en && !rd_empty;

        count_d  = count_q + CW'(push) - CW'(pop);
        wr_ptr_d = wr_ptr_q + RD_DEPTH_WIDTH'(push);
        rd_ptr_d = rd_ptr_q + RD_DEPTH_WIDTH'(pop);

        // A push request always empties the packer, even when storage is full and the word is lost.
        if (push_req) begin
            lane_cnt_d = '0;
            packer_d   = '0;
        end else begin
            lane_cnt_d = lane_next;
            packer_d   = packer_next;
        end

        rd_data_d  = rd_data_q;
        rd_lanes_d = rd_lanes_q;
        if (pop) begin
            {rd_lanes_d, rd_data_d} = mem_q[rd_ptr_q];
        end

        overflow_d  = (overflow_q && !err_clr) || (wr_en && wr_full) || (push_req && count_full);
        underflow_d = (underflow_q && !err_clr) || (rd_en && rd_empty);
    end

    // NOTE: storage has no reset so it maps onto block RAM; pointers and count guard its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {lane_next, packer_next};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            lane_cnt_q  <= '0;
            packer_q    <= '0;
            rd_data_q   <= '0;
            rd_lanes_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            lane_cnt_q  <= lane_cnt_d;
            packer_q    <= packer_d;
            rd_data_q   <= rd_data_d;
            rd_lanes_q  <= rd_lanes_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_upsize_sync_fifo.sv
// Self-checking bench for upsize_sync_fifo: scoreboard of expected wide words popped by a
// monitor on every accepted read, plus directed flag/level checks and an MSB_FIRST instance.
module tb_upsize_sync_fifo;

    typedef logic [259:0] exp_t;

    logic          clk;
    logic          tb_rst;

    logic          wr_en, wr_flush, rd_en, err_clr;
    logic [31:0]   wr_data;
    logic          wr_full, almost_full, rd_empty, almost_empty, overflow, underflow;
    logic [13:0]   wr_water_level;
    logic [255:0]  rd_data;
    logic [3:0]    rd_lanes;
    logic [10:0]   rd_water_level;

    logic          m_wr_en, m_wr_flush, m_rd_en, m_err_clr;
    logic [31:0]   m_wr_data;
    logic          m_wr_full, m_almost_full, m_rd_empty, m_almost_empty, m_overflow, m_underflow;
    logic [5:0]    m_wr_water_level;
    logic [255:0]  m_rd_data;
    logic [3:0]    m_rd_lanes;
    logic [2:0]    m_rd_water_level;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    upsize_sync_fifo dut (
        .clk(clk), .tb_rst(tb_rst),
        .wr_en(wr_en), .wr_data(wr_data), .wr_flush(wr_flush),
        .wr_full(wr_full), .almost_full(almost_full), .wr_water_level(wr_water_level),
        .rd_en(rd_en), .rd_data(rd_data), .rd_lanes(rd_lanes),
        .rd_empty(rd_empty), .almost_empty(almost_empty), .rd_water_level(rd_water_level),
        .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
    );

    upsize_sync_fifo #(
        .RD_DEPTH_WIDTH(2), .ALMOST_FULL_NUM(3), .ALMOST_EMPTY_NUM(1), .PACK_ORDER("MSB_FIRST")
    ) u_msb (
        .clk(clk), .tb_rst(tb_rst),
        .wr_en(m_wr_en), .wr_data(m_wr_data), .wr_flush(m_wr_flush),
        .wr_full(m_wr_full), .almost_full(m_almost_full), .wr_water_level(m_wr_water_level),
        .rd_en(m_rd_en), .rd_data(m_rd_data), .rd_lanes(m_rd_lanes),
        .rd_empty(m_rd_empty), .almost_empty(m_almost_empty), .rd_water_level(m_rd_water_level),
        .overflow(m_overflow), .underflow(m_underflow), .err_clr(m_err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [263:0] act, input logic [263:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t pack_exp(input int base);
        logic [255:0] d;
        d = '0;
        for (int l = 0; l < 8; l++) d[l*32 +: 32] = 32'(base + l);
        return {4'd8, d};
    endfunction

    // One clock of stimulus on the default instance, inputs changed 1 time unit after the edge.
    task automatic cyc(input logic en, input logic [31:0] d, input logic fl, input logic rd,
                       input logic clr);
        wr_en = en; wr_data = d; wr_flush = fl; rd_en = rd; err_clr = clr;
        @(posedge clk); #1;
        wr_en = 1'b0; wr_data = '0; wr_flush = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    endtask

    task automatic mcyc(input logic en, input logic [31:0] d, input logic fl, input logic rd);
        m_wr_en = en; m_wr_data = d; m_wr_flush = fl; m_rd_en = rd;
        @(posedge clk); #1;
        m_wr_en = 1'b0; m_wr_data = '0; m_wr_flush = 1'b0; m_rd_en = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
    endtask

    // Monitor: a read seen with data available is compared on the following negedge.
    initial begin
        bit   pend;
        exp_t e;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (tb_rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if (sb_q.size() == 0) begin
                        check("sb_underrun", 264'(sb_q.size()), 264'd1);
                    end else begin
                        e = sb_q.pop_front();
                        check("rd_word", {rd_lanes, rd_data}, e);
                    end
                end
                pend = rd_en && !rd_empty;
            end
        end
    end

    initial begin
        tb_rst = 1'b1;
        wr_en = 1'b0; wr_data = '0; wr_flush = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
        m_wr_en = 1'b0; m_wr_data = '0; m_wr_flush = 1'b0; m_rd_en = 1'b0; m_err_clr = 1'b0;

        // Reset values
        #12;
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_lanes", rd_lanes, 0);
        check("rst_rd_empty", rd_empty, 1);
        check("rst_almost_empty", almost_empty, 1);
        check("rst_wr_full", wr_full, 0);
        check("rst_almost_full", almost_full, 0);
        check("rst_wr_wl", wr_water_level, 0);
        check("rst_rd_wl", rd_water_level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_underflow", underflow, 0);
        @(negedge clk);
        tb_rst = 1'b0;
        @(posedge clk); #1;

        // Full-word pack and read
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
            if (i == 3) begin
                check("pack_wr_wl_3", wr_water_level, 3);
                check("pack_empty_3", rd_empty, 1);
            end
        end
        sb_q.push_back({4'd8,
            256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001});
        check("pack_rd_wl", rd_water_level, 1);
        check("pack_rd_empty", rd_empty, 0);
        check("pack_wr_wl", wr_water_level, 8);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
        settle();
        check("pack_drained", rd_empty, 1);

        // Partial flush, no-op flush, flush with same-cycle write
        cyc(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
        check("flush_pre_wl", wr_water_level, 3);
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
        sb_q.push_back({4'd3, 256'h0000000C_0000000B_0000000A});
        check("flush_wr_wl", wr_water_level, 8);
        check("flush_rd_wl", rd_water_level, 1);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
        check("flush_noop_rd_wl", rd_water_level, 0);
        check("flush_noop_wr_wl", wr_water_level, 0);
        cyc(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h22, 1'b1, 1'b0, 1'b0);
        sb_q.push_back({4'd2, 256'h00000022_00000011});
        check("flush_wr_rd_wl", rd_water_level, 1);
        check("flush_wr_wr_wl", wr_water_level, 8);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
        settle();

        // Empty read and sticky underflow
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
        check("uf_set", underflow, 1);
        check("uf_rd_data_hold", rd_data, 256'h00000022_00000011);
        check("uf_rd_lanes_hold", rd_lanes, 2);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b1);
        check("uf_set_beats_clr", underflow, 1);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
        check("uf_clr", underflow, 0);

        // Fill to capacity
        for (int i = 0; i < 8192; i++) begin
            cyc(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
            if (i % 8 == 7) sb_q.push_back(pack_exp(i - 7));
            if (i == 8151) check("af_below", almost_full, 0);
            if (i == 8159) check("af_at", almost_full, 1);
        end
        check("fill_rd_wl", rd_water_level, 1024);
        check("fill_wr_full_lane0", wr_full, 0);
        check("fill_almost_full", almost_full, 1);
        for (int i = 8192; i < 8199; i++) cyc(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
        check("fill_wr_full", wr_full, 1);
        check("fill_wr_wl", wr_water_level, 8199);
        cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        check("drop_overflow", overflow, 1);
        check("drop_wr_wl", wr_water_level, 8199);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
        check("drop_read_rd_wl", rd_water_level, 1023);
        check("drop_read_wr_full", wr_full, 0);
        cyc(1'b1, 32'(8199), 1'b0, 1'b0, 1'b0);
        sb_q.push_back(pack_exp(8192));
        check("refill_rd_wl", rd_water_level, 1024);
        check("refill_wr_wl", wr_water_level, 8192);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
        check("ovf_clr", overflow, 0);
        cyc(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
        check("full_partial_wr_wl", wr_water_level, 8193);
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
        check("full_flush_overflow", overflow, 1);
        check("full_flush_wr_wl", wr_water_level, 8192);
        check("full_flush_rd_wl", rd_water_level, 1024);

        // Drain everything
        for (int k = 1; k <= 1024; k++) begin
            cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
            if (k == 1019) check("ae_above", almost_empty, 0);
            if (k == 1020) check("ae_at", almost_empty, 1);
        end
        settle();
        check("drain_empty", rd_empty, 1);
        check("drain_sb_empty", 264'(sb_q.size()), 0);

        // Mid-stream reset: 3 stored words plus 5 in the packer
        for (int i = 0; i < 29; i++) cyc(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0, 1'b0);
        check("pre_rst_rd_wl", rd_water_level, 3);
        #1;
        tb_rst = 1'b1;
        #1;
        sb_q.delete();
        check("mid_rst_rd_wl", rd_water_level, 0);
        check("mid_rst_wr_wl", wr_water_level, 0);
        check("mid_rst_empty", rd_empty, 1);
        check("mid_rst_overflow", overflow, 0);
        check("mid_rst_rd_data", rd_data, 0);
        check("mid_rst_rd_lanes", rd_lanes, 0);
        @(negedge clk);
        tb_rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 1; i <= 8; i++) cyc(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0);
        sb_q.push_back({4'd8,
            256'h00000108_00000107_00000106_00000105_00000104_00000103_00000102_00000101});
        check("post_rst_rd_wl", rd_water_level, 1);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
        settle();
        check("post_rst_sb_empty", 264'(sb_q.size()), 0);

        // MSB_FIRST instance
        for (int i = 1; i <= 8; i++) mcyc(1'b1, 32'(i), 1'b0, 1'b0);
        check("msb_rd_wl", m_rd_water_level, 1);
        mcyc(1'b0, 0, 1'b0, 1'b1);
        check("msb_rd_data", m_rd_data,
            256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008);
        check("msb_rd_lanes", m_rd_lanes, 8);
        mcyc(1'b1, 32'hA, 1'b0, 1'b0);
        mcyc(1'b0, 0, 1'b1, 1'b0);
        mcyc(1'b0, 0, 1'b0, 1'b1);
        check("msb_flush_data", m_rd_data, {32'hA, 224'h0});
        check("msb_flush_lanes", m_rd_lanes, 1);
        check("msb_underflow", m_underflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
